// File: rtl/uart_tx_buffered_if.sv
// Write-side handshake between a producer and the buffered UART transmitter.
interface uart_tx_buffered_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             tx_req;
  logic [WIDTH-1:0] tx_din;
  logic             tx_ready;

  modport master (
    output tx_req,
    output tx_din,
    input  tx_ready
  );

  modport slave (
    input  tx_req,
    input  tx_din,
    output tx_ready
  );

endinterface

// File: rtl/uart_tx_buffered.sv
// UART transmitter with a write FIFO. Frame settings are captured with each popped word, so
// reconfiguring mid-frame only affects later frames.
module uart_tx_buffered #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  uart_tx_buffered_if.slave                 wr_if,
  input  logic [1:0]                        cfg_parity,
  input  logic [1:0]                        cfg_stop_bits,
  input  logic [DIV_W-1:0]                  cfg_clk_div,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              tx_busy,
  output logic                              uart_tx
);

  localparam int unsigned LvlW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned BitW = $clog2(WIDTH);
  localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);
  localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // ---------------------------------------------------------------------------------------------
  // Transmit FIFO
  // ---------------------------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  count_q, count_d;
  logic             ready_q;
  logic             push, pop;
  logic [WIDTH-1:0] head;
  logic             fifo_nonempty;

  // Acceptance uses only the registered ready, so a same-cycle pop never frees a full FIFO.
  assign push          = wr_if.tx_req & ready_q;
  assign head          = mem_q[rd_ptr_q];
  assign fifo_nonempty = (count_q != '0);

  always_comb begin
    count_d = count_q + LvlW'(push) - LvlW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      ready_q <= (count_d != LvlFull);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_if.tx_din;
  end

  assign wr_if.tx_ready = ready_q;
  assign fifo_level     = count_q;

  // ---------------------------------------------------------------------------------------------
  // Frame sequencer
  // ---------------------------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_m1_q, div_m1_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic             par_en_q, par_en_d;
  logic             par_bit_q, par_bit_d;
  logic             stop_two_q, stop_two_d;
  logic             stop_idx_q, stop_idx_d;
  logic             uart_tx_q, uart_tx_d;
  logic             busy_q, busy_d;
  logic             load;
  logic             bit_done;
  logic [DIV_W-1:0] cfg_div_m1;

  assign bit_done   = (cnt_q == '0);
  assign cfg_div_m1 = (cfg_clk_div == '0) ? '0 : cfg_clk_div - DIV_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = bit_done ? cnt_q : cnt_q - DIV_W'(1);
    div_m1_d   = div_m1_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop_two_d = stop_two_q;
    stop_idx_d = stop_idx_q;
    load       = 1'b0;

    case (state_q)
      StIdle: begin
        if (fifo_nonempty) load = 1'b1;
      end
      StStart: begin
        if (bit_done) begin
          state_d = StData;
          cnt_d   = div_m1_q;
          bit_d   = '0;
        end
      end
      StData: begin
        if (bit_done) begin
          cnt_d   = div_m1_q;
          shift_d = shift_q >> 1;
          if (bit_q == LastBit) begin
            state_d    = par_en_q ? StParity : StStop;
            stop_idx_d = 1'b0;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      StParity: begin
        if (bit_done) begin
          state_d    = StStop;
          cnt_d      = div_m1_q;
          stop_idx_d = 1'b0;
        end
      end
      StStop: begin
        if (bit_done) begin
          if (stop_two_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
            cnt_d      = div_m1_q;
          end else if (fifo_nonempty) begin
            load = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Pop and capture the frame settings together so the whole frame uses one configuration.
    if (load) begin
      state_d    = StStart;
      shift_d    = head;
      cnt_d      = cfg_div_m1;
      div_m1_d   = cfg_div_m1;
      par_en_d   = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
      par_bit_d  = (^head) ^ (cfg_parity == 2'b10);
      stop_two_d = (cfg_stop_bits == 2'b01);
      stop_idx_d = 1'b0;
    end
    pop = load;
  end

  // The line and busy flag are registered from the current state, one clock behind the FSM.
  always_comb begin
    case (state_q)
      StStart:  uart_tx_d = 1'b0;
      StData:   uart_tx_d = shift_q[0];
      StParity: uart_tx_d = par_bit_q;
      default:  uart_tx_d = 1'b1;
    endcase
    busy_d = (state_q != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      div_m1_q   <= '0;
      shift_q    <= '0;
      bit_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop_two_q <= 1'b0;
      stop_idx_q <= 1'b0;
      uart_tx_q  <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_m1_q   <= div_m1_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop_two_q <= stop_two_d;
      stop_idx_q <= stop_idx_d;
      uart_tx_q  <= uart_tx_d;
      busy_q     <= busy_d;
    end
  end

  assign uart_tx = uart_tx_q;
  assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: expected frames are queued at stimulus time and a line
// monitor pops and compares each frame as it appears on uart_tx.
module tb_uart_tx_buffered;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned DW = 16;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [1:0]                 cfg_parity;
  logic [1:0]                 cfg_stop_bits;
  logic [DW-1:0]              cfg_clk_div;
  logic [$clog2(D+1)-1:0]     fifo_level;
  logic                       tx_busy;
  logic                       uart_tx;

  uart_tx_buffered_if #(.WIDTH(W)) wr_if ();

  uart_tx_buffered #(
    .WIDTH      (W),
    .FIFO_DEPTH (D),
    .DIV_W      (DW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_if         (wr_if),
    .cfg_parity    (cfg_parity),
    .cfg_stop_bits (cfg_stop_bits),
    .cfg_clk_div   (cfg_clk_div),
    .fifo_level    (fifo_level),
    .tx_busy       (tx_busy),
    .uart_tx       (uart_tx)
  );

  always #5 clk = ~clk;

  // bits[0] is the first bit on the line (start bit).
  typedef struct {
    int          nbits;
    logic [15:0] bits;
    int          period;
    bit          b2b;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic expect_frame(input int nbits, input logic [15:0] bits, input int period,
                              input bit b2b);
    exp_t e;
    e.nbits  = nbits;
    e.bits   = bits;
    e.period = period;
    e.b2b    = b2b;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [7:0] d);
    @(negedge clk);
    wr_if.tx_req = 1'b1;
    wr_if.tx_din = d;
    @(posedge clk);
    #1 wr_if.tx_req = 1'b0;
  endtask

  // Called right after wr(): the line must stay high at E+1, go low at E+2, busy for exp_busy.
  task automatic check_timing(input int exp_busy, input string tag);
    int n;
    @(posedge clk);
    #1 check({tag, "_e1_idle"}, 32'(uart_tx), 32'd1);
    @(posedge clk);
    #1 check({tag, "_e2_start"}, 32'(uart_tx), 32'd0);
    n = 0;
    while (tx_busy === 1'b1 && n < 500) begin
      n++;
      @(posedge clk);
      #1;
    end
    check({tag, "_busy_len"}, 32'(n), 32'(exp_busy));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_busy) && n < 30000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 30000) begin
      errors++;
      $display("FAIL drain_timeout: got %0d frames pending required 0", sb.size());
    end
    repeat (4) @(posedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    int   idle;
    bit   bad;
    int   bad_bit;
    logic bad_val;
    idle = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1 || sb.size() == 0) begin
        idle = 0;
      end else if (uart_tx === 1'b1) begin
        idle++;
        if (idle > 5000) begin
          e = sb.pop_front();
          checks++;
          errors++;
          $display("FAIL frame_timeout: got no start bit required frame %0h", e.bits);
          idle = 0;
        end
      end else begin
        e        = sb.pop_front();
        mon_busy = 1'b1;
        if (e.b2b) begin
          checks++;
          if (idle != 0) begin
            errors++;
            $display("FAIL b2b_gap: got %0d idle cycles required 0", idle);
          end
        end
        bad     = 1'b0;
        bad_bit = -1;
        bad_val = 1'b0;
        for (int i = 0; i < e.nbits; i++) begin
          for (int c = 0; c < e.period; c++) begin
            if (i != 0 || c != 0) @(negedge clk);
            if (!bad && uart_tx !== e.bits[i]) begin
              bad     = 1'b1;
              bad_bit = i;
              bad_val = uart_tx;
            end
          end
        end
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL frame_%0h: bit %0d got %b required %b", e.bits, bad_bit, bad_val,
                   e.bits[bad_bit]);
        end
        idle     = 0;
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: got no finish required finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin : stim
    bit stray;
    wr_if.tx_req  = 1'b0;
    wr_if.tx_din  = '0;
    cfg_parity    = 2'b00;
    cfg_stop_bits = 2'b00;
    cfg_clk_div   = 16'd4;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(wr_if.tx_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // 0xA5, no parity, one stop, 4 clocks/bit
    expect_frame(10, 16'h034A, 4, 1'b0);
    wr(8'hA5);
    check_timing(40, "none");
    drain();

    cfg_parity = 2'b01;
    expect_frame(11, 16'h054A, 4, 1'b0);
    wr(8'hA5);
    check_timing(44, "even");
    drain();

    cfg_parity = 2'b10;
    expect_frame(11, 16'h074A, 4, 1'b0);
    wr(8'hA5);
    check_timing(44, "odd");
    drain();

    // Divider 0 behaves as 1, two stop bits, back-to-back frames
    cfg_parity    = 2'b00;
    cfg_stop_bits = 2'b01;
    cfg_clk_div   = 16'd0;
    expect_frame(11, 16'h0600, 1, 1'b0);
    expect_frame(11, 16'h07FE, 1, 1'b1);
    wr(8'h00);
    wr(8'hFF);
    drain();

    // Overfill a 4-deep FIFO: word 6 dropped
    cfg_stop_bits = 2'b00;
    cfg_clk_div   = 16'd100;
    expect_frame(10, 16'h0202, 100, 1'b0);
    expect_frame(10, 16'h0204, 100, 1'b0);
    expect_frame(10, 16'h0206, 100, 1'b0);
    expect_frame(10, 16'h0208, 100, 1'b0);
    expect_frame(10, 16'h020A, 100, 1'b0);
    @(negedge clk);
    wr_if.tx_req = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      wr_if.tx_din = 8'(i);
      @(negedge clk);
    end
    wr_if.tx_req = 1'b0;
    check("full_level", 32'(fifo_level), 32'd4);
    check("full_ready", 32'(wr_if.tx_ready), 32'd0);
    drain();

    // Divider change mid-frame applies only to the next frame
    cfg_clk_div = 16'd4;
    expect_frame(10, 16'h0278, 4, 1'b0);
    expect_frame(10, 16'h0386, 8, 1'b0);
    wr(8'h3C);
    repeat (10) @(posedge clk);
    @(negedge clk);
    cfg_clk_div = 16'd8;
    wr(8'hC3);
    drain();

    // Reset mid-DATA with three words queued: nothing further is sent
    cfg_clk_div = 16'd4;
    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    wr(8'h44);
    check("queued_level", 32'(fifo_level), 32'd3);
    repeat (12) @(posedge clk);
    #1 check("midframe_busy", 32'(tx_busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_uart_tx", 32'(uart_tx), 32'd1);
    check("abort_level", 32'(fifo_level), 32'd0);
    check("abort_busy", 32'(tx_busy), 32'd0);
    check("abort_ready", 32'(wr_if.tx_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) stray = 1'b1;
    end
    check("abort_quiet", 32'(stray), 32'd0);

    expect_frame(10, 16'h02B4, 4, 1'b0);
    wr(8'h5A);
    check_timing(40, "post_rst");
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
